// File: rtl/bramctl_mp_if.sv
// bramctl_mp requester bus: per-channel request fields packed by channel,
// plus the shared ack/rdata/busy return path.
interface bramctl_mp_if #(
  parameter int NCH = 2,
  parameter int DW  = 40,
  parameter int AW  = 16
);
  logic [AW-1:0]       arraywidth;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      rw;
  logic [2*NCH-1:0]    mode;
  logic [AW*NCH-1:0]   addr;
  logic [3*DW*NCH-1:0] wdata;
  logic [NCH-1:0]      ack;
  logic [3*DW-1:0]     rdata;
  logic                busy;

  modport master (
    output arraywidth, req, rw, mode, addr, wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  arraywidth, req, rw, mode, addr, wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/bramctl_mp.sv
// Multi-channel byte-serial BRAM controller with round-robin grant
// and BYTE/HALF/WORD/NEIG transfer modes.
module bramctl_mp #(
  parameter int NCH   = 2,
  parameter int DW    = 40,
  parameter int AW    = 16,
  parameter int DEPTH = 256
) (
  input logic      clk,
  input logic      rst,
  bramctl_mp_if.slave bus
);
  localparam int NB = DW / 8;
  localparam int IW = $clog2(3 * NB + 1);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DA = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t st, st_nxt;

  logic [CW-1:0]   ptr, gnt, pick;
  logic            found;
  logic            lrw;
  logic [1:0]      lmode;
  logic [AW-1:0]   laddr, law;
  logic [3*DW-1:0] lwdata, acc, acc_nxt, rdata_q;
  logic [IW-1:0]   i, n, j, k;
  logic [AW-1:0]   ba;
  logic [DA-1:0]   ma;
  logic [7:0]      rbyte;
  logic            last;
  logic [7:0]      mem [DEPTH];

  // first requester strictly after the pointer, wrapping
  always_comb begin : arb
    int c;
    found = 1'b0;
    pick  = ptr;
    c     = 0;
    for (int m = 1; m <= NCH; m++) begin
      c = (int'(ptr) + m) % NCH;
      if (!found && bus.req[c]) begin
        found = 1'b1;
        pick  = CW'(c);
      end
    end
  end

  always_comb begin
    n = IW'(3 * NB);
    unique case (lmode)
      2'd0:    n = IW'(1);
      2'd1:    n = IW'(2);
      2'd2:    n = IW'(NB);
      default: n = IW'(3 * NB);
    endcase
  end

  always_comb begin
    j  = i / IW'(NB);
    k  = i % IW'(NB);
    ba = laddr + AW'(i);
    if (lmode == 2'd3)
      ba = laddr - law - AW'(1)
         + AW'(j) * law + AW'(k);
    ma    = ba[DA-1:0];
    rbyte = mem[ma];
    last  = (i == n - IW'(1));
    acc_nxt = acc;
    acc_nxt[{i, 3'b000} +: 8] = rbyte;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (found) st_nxt = XFER;
      XFER:    if (last) st_nxt = DONE;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ack = '0;
    if (st == DONE) bus.ack[gnt] = 1'b1;
  end

  assign bus.busy  = (st != IDLE);
  assign bus.rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      ptr     <= CW'(NCH - 1);
      gnt     <= '0;
      lrw     <= 1'b0;
      lmode   <= '0;
      laddr   <= '0;
      law     <= '0;
      lwdata  <= '0;
      i       <= '0;
      acc     <= '0;
      rdata_q <= '0;
    end else begin
      st <= st_nxt;
      if (st == IDLE && found) begin
        gnt    <= pick;
        ptr    <= pick;
        lrw    <= bus.rw[pick];
        lmode  <= bus.mode[pick*2 +: 2];
        laddr  <= bus.addr[pick*AW +: AW];
        lwdata <= bus.wdata[pick*3*DW +: 3*DW];
        law    <= bus.arraywidth;
        i      <= '0;
        acc    <= '0;
      end
      if (st == XFER) begin
        i <= i + IW'(1);
        if (lrw) begin
          acc <= acc_nxt;
          if (last) rdata_q <= acc_nxt;
        end
      end
    end
  end

  // storage is never reset; an aborted write keeps bytes already stored
  always_ff @(posedge clk) begin
    if (!rst && st == XFER && !lrw)
      mem[ma] <= lwdata[{i, 3'b000} +: 8];
  end
endmodule

// File: tb/tb_bramctl_mp.sv
// Testbench for bramctl_mp: vector table with a read-data scoreboard,
// plus arbitration and reset-abort sequences.
module tb_bramctl_mp;
  localparam int NCH = 2;
  localparam int DW  = 40;
  localparam int AW  = 16;

  typedef struct {
    int          ch;
    bit          rw;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [15:0] aw;
    logic [119:0] wd;
    logic [119:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   err = 0;

  logic [119:0] sb[$];
  int           gq[$];
  vec_t         tbl[18];

  localparam logic [119:0] NA = 120'h000000000a;
  localparam logic [119:0] NB_ = 120'h000000000b;
  localparam logic [119:0] NC = 120'h000000000c;
  localparam logic [119:0] NABC = {40'ha, 40'hb, 40'hc};
  localparam logic [119:0] W123 =
    {40'h3333333333, 40'h2222222222, 40'h1111111111};

  bramctl_mp_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus();

  bramctl_mp #(.NCH(NCH), .DW(DW), .AW(AW), .DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [119:0] got,
                     input logic [119:0] want);
    vec++;
    if (got !== want) begin
      err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    bit got;
    logic [119:0] e;
    bus.rw[v.ch] = v.rw;
    bus.mode[v.ch*2 +: 2] = v.mode;
    bus.addr[v.ch*16 +: 16] = v.addr;
    bus.wdata[v.ch*120 +: 120] = v.wd;
    bus.arraywidth = v.aw;
    if (v.rw) sb.push_back(v.exp);
    bus.req[v.ch] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        bus.addr[v.ch*16 +: 16] = 16'($urandom);
        bus.wdata[v.ch*120 +: 120] = {$urandom, $urandom, $urandom, $urandom};
        bus.mode[v.ch*2 +: 2] = 2'($urandom);
        bus.arraywidth = 16'($urandom);
      end
      if (bus.ack != '0) got = 1'b1;
    end
    bus.req[v.ch] = 1'b0;
    chk($sformatf("latency[%0d]", idx), got ? 120'(cyc) : 120'(0),
        120'(v.lat));
    chk($sformatf("ackch[%0d]", idx), 120'(bus.ack), 120'(1 << v.ch));
    if (v.rw) begin
      e = sb.pop_front();
      chk($sformatf("rdata[%0d]", idx), bus.rdata, e);
    end
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("idle[%0d]", idx), 120'(bus.busy), 120'(0));
  endtask

  initial begin
    int cyc, acks;
    bit sawack;
    vec_t v;

    tbl[0]  = '{0, 1'b0, 2'd2, 16'd8,   16'd0, 120'hdeadbeef23, '0, 6};
    tbl[1]  = '{0, 1'b1, 2'd2, 16'd8,   16'd0, '0, 120'hdeadbeef23, 6};
    tbl[2]  = '{1, 1'b0, 2'd2, 16'd0,   16'd0, 120'hfeedface45, '0, 6};
    tbl[3]  = '{1, 1'b0, 2'd0, 16'd3,   16'd0, 120'hdeadbeef23, '0, 2};
    tbl[4]  = '{0, 1'b1, 2'd2, 16'd0,   16'd0, '0, 120'hfe23face45, 6};
    tbl[5]  = '{1, 1'b1, 2'd1, 16'd3,   16'd0, '0, 120'hfe23, 3};
    tbl[6]  = '{0, 1'b0, 2'd2, 16'd0,   16'd0, 120'hfeedface45, '0, 6};
    tbl[7]  = '{0, 1'b0, 2'd2, 16'd3,   16'd0, 120'h1122334455, '0, 6};
    tbl[8]  = '{1, 1'b1, 2'd2, 16'd0,   16'd0, '0, 120'h4455face45, 6};
    tbl[9]  = '{0, 1'b1, 2'd2, 16'd5,   16'd0, '0, 120'hef23112233, 6};
    tbl[10] = '{0, 1'b0, 2'd3, 16'd87,  16'd6, NABC, '0, 16};
    tbl[11] = '{1, 1'b1, 2'd2, 16'd80,  16'd0, '0, NC, 6};
    tbl[12] = '{0, 1'b1, 2'd2, 16'd86,  16'd0, '0, NB_, 6};
    tbl[13] = '{1, 1'b1, 2'd2, 16'd92,  16'd0, '0, NA, 6};
    tbl[14] = '{0, 1'b1, 2'd3, 16'd87,  16'd6, '0, NABC, 16};
    tbl[15] = '{1, 1'b0, 2'd3, 16'd3,   16'd6, W123, '0, 16};
    tbl[16] = '{0, 1'b1, 2'd2, 16'd252, 16'd0, '0, 120'h1111111111, 6};
    tbl[17] = '{1, 1'b1, 2'd2, 16'd254, 16'd0, '0, 120'h22ce111111, 6};

    bus.req = '0;
    bus.rw = '0;
    bus.mode = '0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.arraywidth = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 120'(bus.busy), 120'(0));
    chk("rst_ack", 120'(bus.ack), 120'(0));
    chk("rst_rdata", bus.rdata, '0);
    rst = 1'b0;

    for (int t = 0; t < 18; t++) run_op(tbl[t], t);

    // arbitration: both channels requesting continuously from reset
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      bus.rw[c] = 1'b1;
      bus.mode[c*2 +: 2] = 2'd2;
      bus.addr[c*16 +: 16] = 16'd80;
    end
    gq = '{0, 1, 0, 1};
    bus.req = 2'b11;
    cyc = 0;
    acks = 0;
    while (acks < 4 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.ack != '0) begin
        chk($sformatf("arb_ack[%0d]", acks), 120'(bus.ack),
            120'(1 << gq.pop_front()));
        chk($sformatf("arb_rdata[%0d]", acks), bus.rdata, NC);
        acks++;
      end
    end
    bus.req = '0;
    chk("arb_count", 120'(acks), 120'(4));
    @(posedge clk);
    @(negedge clk);

    // reset during the 4th transfer cycle of a NEIG read
    bus.rw[0] = 1'b1;
    bus.mode[1:0] = 2'd3;
    bus.addr[15:0] = 16'd87;
    bus.arraywidth = 16'd6;
    bus.req[0] = 1'b1;
    sawack = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ack != '0) sawack = 1'b1;
    end
    chk("abort_busy_before", 120'(bus.busy), 120'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req[0] = 1'b0;
    chk("abort_busy", 120'(bus.busy), 120'(0));
    chk("abort_rdata", bus.rdata, '0);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ack != '0) sawack = 1'b1;
    end
    chk("abort_noack", 120'(sawack), 120'(0));

    v = '{0, 1'b1, 2'd2, 16'd80, 16'd0, '0, NC, 6};
    run_op(v, 99);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
